systolic_feed_ctrl: RTL

SYSTOLIC_FEED_CTRL -- requirements
Module: systolic_feed_ctrl

---
 rtl/systolic_feed_ctrl_if.sv | 34 +++
 rtl/systolic_feed_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/systolic_feed_ctrl_if.sv
// systolic_feed_ctrl_if: host/array bus bundle for the systolic feed controller.
//   Host side (master) drives the pass request and operand-buffer writes;
//   controller side (slave) drives the status and the skewed PE feed.
//   start        pass request
//   wr_en/wr_sel/wr_addr/wr_data  operand write port (sel 0 = A, 1 = B)
//   busy, done   pass status
//   pe_clr, pe_en, feed_valid     PE array control
//   left_data, up_data            skewed row / column operands (3 lanes of DW)
interface systolic_feed_ctrl_if #(
  parameter int unsigned DW = 8
) ();
  logic            start;
  logic            wr_en;
  logic            wr_sel;
  logic [3:0]      wr_addr;
  logic [DW-1:0]   wr_data;
  logic            busy;
  logic            done;
  logic            pe_clr;
  logic            pe_en;
  logic            feed_valid;
  logic [3*DW-1:0] left_data;
  logic [3*DW-1:0] up_data;

  modport master (
    output start, wr_en, wr_sel, wr_addr, wr_data,
    input  busy, done, pe_clr, pe_en, feed_valid, left_data, up_data
  );

  modport slave (
    input  start, wr_en, wr_sel, wr_addr, wr_data,
    output busy, done, pe_clr, pe_en, feed_valid, left_data, up_data
  );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: sequences one 3x3 matrix-multiply pass on an
// output-stationary systolic array. Holds the A/B operand buffers, clears
// the PE accumulators, feeds skewed operands for 5 cycles, drains for 3
// and pulses done.
//   clk    clock, rising edge
//   reset  asynchronous, active-high
//   bus    systolic_feed_ctrl_if.slave (see interface for signal list)
//   perf_passes  16-bit completed-pass counter, only present when the
//                SYSTOLIC_CTRL_PERF_EN macro is defined
// All outputs are flops loaded from the next-state decode.
module systolic_feed_ctrl #(
  parameter int unsigned DW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  systolic_feed_ctrl_if.slave  bus
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [15:0]          perf_passes
`endif
);

  localparam int unsigned N         = 3;
  localparam int unsigned NE        = N * N;
  localparam int unsigned AW        = 4;
  localparam int unsigned CW        = 3;
  localparam int unsigned FEED_LEN  = 5;
  localparam int unsigned DRAIN_LEN = 3;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [DW-1:0]   a_buf [NE];
  logic [DW-1:0]   b_buf [NE];

  logic            busy_d, done_d, pe_clr_d, pe_en_d, feed_d;
  logic [N*DW-1:0] left_d, up_d;

  // State and phase counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state plus decode of the values the output flops load
  always_comb begin
    int k;
    state_nxt = state;
    cnt_nxt   = cnt;
    left_d    = '0;
    up_d      = '0;
    k         = 0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        state_nxt = FEED;
        cnt_nxt   = '0;
      end
      FEED: begin
        if (cnt == CW'(FEED_LEN - 1)) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DRAIN: begin
        if (cnt == CW'(DRAIN_LEN - 1)) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy_d   = (state_nxt == CLEAR) || (state_nxt == FEED) || (state_nxt == DRAIN);
    done_d   = (state_nxt == DONE);
    pe_clr_d = (state_nxt == CLEAR);
    pe_en_d  = (state_nxt == FEED) || (state_nxt == DRAIN);
    feed_d   = (state_nxt == FEED);

    // Lane i carries diagonal index k = t - i: A[i][k] on row i, B[k][i] on column i
    for (int i = 0; i < int'(N); i++) begin
      k = int'(cnt_nxt) - i;
      if (feed_d && (k >= 0) && (k < int'(N))) begin
        left_d[i*DW +: DW] = a_buf[AW'(i * int'(N) + k)];
        up_d[i*DW +: DW]   = b_buf[AW'(k * int'(N) + i)];
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.pe_clr     <= 1'b0;
      bus.pe_en      <= 1'b0;
      bus.feed_valid <= 1'b0;
      bus.left_data  <= '0;
      bus.up_data    <= '0;
    end else begin
      bus.busy       <= busy_d;
      bus.done       <= done_d;
      bus.pe_clr     <= pe_clr_d;
      bus.pe_en      <= pe_en_d;
      bus.feed_valid <= feed_d;
      bus.left_data  <= left_d;
      bus.up_data    <= up_d;
    end
  end

  // Operand buffers: writable only in IDLE so a pass sees frozen operands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < int'(NE); e++) begin
        a_buf[AW'(e)] <= '0;
        b_buf[AW'(e)] <= '0;
      end
    end else if ((state == IDLE) && bus.wr_en && (bus.wr_addr < AW'(NE))) begin
      if (bus.wr_sel) begin
        b_buf[bus.wr_addr] <= bus.wr_data;
      end else begin
        a_buf[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

`ifdef SYSTOLIC_CTRL_PERF_EN
  // Completed-pass counter, bumps as DONE is entered, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_passes <= '0;
    end else if (done_d) begin
      perf_passes <= perf_passes + 16'd1;
    end
  end
`endif

endmodule
